// File: rtl/mpu_data_types.sv
// Shared MPU data types: the load FSM state encoding, the single-precision
// element type, and the +0.0 constant used when zero-padding a matrix.
package mpu_data_types;

  // Load FSM states; LOAD_PAD still fits the original 2-bit encoding.
  typedef enum logic [1:0] {
    LOAD_IDLE    = 2'd0,
    LOAD_REQUEST = 2'd1,
    LOAD_MATRIX  = 2'd2,
    LOAD_PAD     = 2'd3
  } load_state_e;

  // IEEE-754 single-precision bit pattern, carried opaquely.
  typedef logic [31:0] float_sp;

  localparam float_sp POS_ZERO_32BIT = 32'h0000_0000;

endpackage

// File: rtl/mpu_index_counter.sv
// Row-major (row, col) cursor for the matrix loader.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   clear               return the cursor to (0,0)
//   load, load_row/col  jump directly to a cell (used to step through padding)
//   advance             step one column, wrapping to the next row
//   col_last            current column is the last one of the active width
//   row, col            current cursor position
module mpu_index_counter #(
  parameter int unsigned RW = 2,
  parameter int unsigned CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          load,
  input  logic          advance,
  input  logic          col_last,
  input  logic [RW-1:0] load_row,
  input  logic [CW-1:0] load_col,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col
);

  // Priority: reset/clear, then direct load, then row-major advance.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row <= '0;
      col <= '0;
    end else if (load) begin
      row <= load_row;
      col <= load_col;
    end else if (advance) begin
      if (col_last) begin
        col <= '0;
        row <= row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mpu_load_stream.sv
// Streams an m_in x n_in matrix of float_sp elements (valid/ready handshake)
// into one entry of the matrix register file, one cell write per accepted
// element, row-major.
// Optional feature: define LOAD_ZERO_PAD_EN to also write +0.0 to every cell
// of the full M x N grid outside the loaded m_in x n_in window.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   start                 load request (ignored while busy)
//   dest_addr, m_in, n_in target register and matrix dimensions
//   elem_valid/elem_data  element stream in; elem_ready high only while loading
//   busy                  loader not idle
//   reg_wr_*              register-file cell write port
//   done                  pulses with the final write of a load
//   error                 pulses when the requested dimensions are invalid
module mpu_load_stream
  import mpu_data_types::*;
#(
  parameter int unsigned FP               = 32,
  parameter int unsigned M                = 3,
  parameter int unsigned N                = 3,
  parameter int unsigned MATRIX_REGISTERS = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [$clog2(MATRIX_REGISTERS)-1:0] dest_addr,
  input  logic [$clog2(M+1)-1:0]              m_in,
  input  logic [$clog2(N+1)-1:0]              n_in,
  input  logic                                elem_valid,
  input  logic [FP-1:0]                       elem_data,
  output logic                                elem_ready,
  output logic                                busy,
  output logic                                reg_wr_en,
  output logic [$clog2(MATRIX_REGISTERS)-1:0] reg_wr_addr,
  output logic [$clog2(M)-1:0]                reg_wr_row,
  output logic [$clog2(N)-1:0]                reg_wr_col,
  output logic [FP-1:0]                       reg_wr_data,
  output logic                                done,
  output logic                                error
);

  localparam int unsigned AW = $clog2(MATRIX_REGISTERS);
  localparam int unsigned MW = $clog2(M+1);
  localparam int unsigned NW = $clog2(N+1);
  localparam int unsigned RW = $clog2(M);
  localparam int unsigned CW = $clog2(N);

  load_state_e   state;
  logic [AW-1:0] addr_q;
  logic [MW-1:0] m_q;
  logic [NW-1:0] n_q;

  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          accept;
  logic          col_last;
  logic          last_elem;
  logic          ctr_clear;
  logic          ctr_load;
  logic [RW-1:0] ld_row;
  logic [CW-1:0] ld_col;

  // Dimensions must be non-zero and fit the physical grid.
  function automatic logic dims_bad(input int unsigned m, input int unsigned n);
    return (m == 0) || (m > M) || (n == 0) || (n > N);
  endfunction

`ifdef LOAD_ZERO_PAD_EN
  logic        pad_first;
  logic        pad_next;
  int unsigned first_r, first_c, next_r, next_c;

  // First grid cell at or after flat index 'from' that lies outside the
  // m x n window; returns 0 when there is none left.
  function automatic logic find_pad(input int unsigned m, input int unsigned n,
                                    input int unsigned from,
                                    output int unsigned r, output int unsigned c);
    logic found;
    found = 1'b0;
    r     = 0;
    c     = 0;
    for (int unsigned i = 0; i < M * N; i++) begin
      if (!found && (i >= from) && (((i / N) >= m) || ((i % N) >= n))) begin
        found = 1'b1;
        r     = i / N;
        c     = i % N;
      end
    end
    return found;
  endfunction
`endif

  // Handshake, end-of-matrix detection and cursor control.
  always_comb begin
    accept    = (state == LOAD_MATRIX) && elem_valid && elem_ready;
    col_last  = (32'(col) + 32'd1) == 32'(n_q);
    last_elem = col_last && ((32'(row) + 32'd1) == 32'(m_q));
    ctr_clear = (state == LOAD_IDLE) && start;
    ctr_load  = 1'b0;
    ld_row    = '0;
    ld_col    = '0;
`ifdef LOAD_ZERO_PAD_EN
    pad_first = find_pad(32'(m_q), 32'(n_q), 32'd0, first_r, first_c);
    pad_next  = find_pad(32'(m_q), 32'(n_q), 32'(row) * N + 32'(col) + 32'd1,
                         next_r, next_c);
    // The cursor jumps straight from the last element to the first pad cell,
    // then from pad cell to pad cell, so every pad cycle writes.
    if (accept && last_elem && pad_first) begin
      ctr_load = 1'b1;
      ld_row   = RW'(first_r);
      ld_col   = CW'(first_c);
    end else if ((state == LOAD_PAD) && pad_next) begin
      ctr_load = 1'b1;
      ld_row   = RW'(next_r);
      ld_col   = CW'(next_c);
    end
`endif
  end

  mpu_index_counter #(
    .RW (RW),
    .CW (CW)
  ) u_index (
    .clk      (clk),
    .rst      (rst),
    .clear    (ctr_clear),
    .load     (ctr_load),
    .advance  (accept),
    .col_last (col_last),
    .load_row (ld_row),
    .load_col (ld_col),
    .row      (row),
    .col      (col)
  );

  // Load FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD_IDLE;
      addr_q      <= '0;
      m_q         <= '0;
      n_q         <= '0;
      elem_ready  <= 1'b0;
      busy        <= 1'b0;
      reg_wr_en   <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_row  <= '0;
      reg_wr_col  <= '0;
      reg_wr_data <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      reg_wr_en <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      case (state)
        LOAD_IDLE: begin
          if (start) begin
            addr_q <= dest_addr;
            m_q    <= m_in;
            n_q    <= n_in;
            // Flag bad dimensions now so the pulse lines up with LOAD_REQUEST.
            error  <= dims_bad(32'(m_in), 32'(n_in));
            busy   <= 1'b1;
            state  <= LOAD_REQUEST;
          end
        end
        LOAD_REQUEST: begin
          if (dims_bad(32'(m_q), 32'(n_q))) begin
            busy  <= 1'b0;
            state <= LOAD_IDLE;
          end else begin
            elem_ready <= 1'b1;
            state      <= LOAD_MATRIX;
          end
        end
        LOAD_MATRIX: begin
          if (accept) begin
            reg_wr_en   <= 1'b1;
            reg_wr_addr <= addr_q;
            reg_wr_row  <= row;
            reg_wr_col  <= col;
            reg_wr_data <= elem_data;
            if (last_elem) begin
              elem_ready <= 1'b0;
`ifdef LOAD_ZERO_PAD_EN
              if (pad_first) begin
                state <= LOAD_PAD;
              end else begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= LOAD_IDLE;
              end
`else
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= LOAD_IDLE;
`endif
            end
          end
        end
`ifdef LOAD_ZERO_PAD_EN
        LOAD_PAD: begin
          reg_wr_en   <= 1'b1;
          reg_wr_addr <= addr_q;
          reg_wr_row  <= row;
          reg_wr_col  <= col;
          reg_wr_data <= FP'(POS_ZERO_32BIT);
          if (!pad_next) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= LOAD_IDLE;
          end
        end
`endif
        default: begin
          elem_ready <= 1'b0;
          busy       <= 1'b0;
          state      <= LOAD_IDLE;
        end
      endcase
    end
  end

endmodule
